hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It generates the flush and enable controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, including the `id_ex_flush` input of the ID/EX register. It resolves three hazards:
- load-use hazards, by inserting 1 or 2 bubbles;
- control redirects from EX, by squashing the wrong-path instructions;
- data-memory wait states, by freezing the whole pipeline, with a timeout flag.

Saturating performance counters track stall and flush activity.

## Interface
- `LOAD_BUBBLES`, default 1: bubbles inserted per load-use hazard. Legal values are 1 (MEM→EX forwarding present) or 2 (no MEM forwarding).
- `MEM_TIMEOUT`, default 255: number of consecutive memory-wait cycles after which `mem_timeout` is set. Legal range is ≥1.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rstn` in 1: reset. Asynchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `id_ex_rd` in 5: destination register of the instruction in EX.
- `id_ex_mem_read`, `id_ex_reg_write` in 1 each: control bits of the instruction in EX.
- `ex_redirect` in 1: a taken branch or jump is resolved in EX this cycle.
- `ex_mem_mem_read`, `ex_mem_mem_write` in 1 each: a memory access is in MEM.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1 each: stage register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: insert a bubble into that register.
- `mem_timeout` out 1: sticky flag, set when the memory wait exceeds `MEM_TIMEOUT`.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `pc_en`=0.
- `flush_count` out `CNT_W`: saturating count of accepted redirects.

## Operation
Definitions:
- `mem_req` = `ex_mem_mem_read` | `ex_mem_mem_write`.
- `mem_stall` = `mem_req` & ~`dmem_ready`.
- `load_use` = `id_ex_mem_read` & `id_ex_reg_write` & (`id_ex_rd`≠0) & ((`id_uses_rs1` & `id_rs1`==`id_ex_rd`) | (`id_uses_rs2` & `id_rs2`==`id_ex_rd`)).

Default outputs: all `*_en`=1 and all flushes=0.

Priority, evaluated each cycle from highest to lowest:
1. `mem_stall`: freeze. `pc_en`=`if_id_en`=`id_ex_en`=`ex_mem_en`=0, `mem_wb_flush`=1, all other flushes 0. The redirect and load-use conditions are ignored this cycle and re-evaluated once the pipeline is released, because the frozen stage inputs are held.
2. `ex_redirect`: `if_id_flush`=1 and `id_ex_flush`=1. Enables stay at 1 so the PC loads the target. This overrides `load_use`, since the ID instruction is on the wrong path.
3. `load_use` (in RUN), or state BUBBLE: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.

State machine (state register; outputs are decoded combinationally from state and inputs):
- RUN:
  - `mem_stall` → MEM_WAIT; save RUN as the return state.
  - `load_use` & `LOAD_BUBBLES`=2 & ~`ex_redirect` → BUBBLE; `bub_cnt` loads 1.
  - Otherwise stay in RUN.
- BUBBLE: drives one more bubble.
  - `mem_stall` → MEM_WAIT; save BUBBLE; `bub_cnt` holds.
  - Otherwise `bub_cnt` decrements, and at 0 → RUN.
- MEM_WAIT: the freeze outputs apply.
  - `wait_cnt` increments, saturating at `MEM_TIMEOUT`.
  - When ~`mem_stall`: return to the saved state, clear `wait_cnt`, and apply the saved state's normal outputs in that same cycle.
  - `mem_timeout` is set on the cycle `wait_cnt` reaches `MEM_TIMEOUT`. It is cleared only by reset, and the stall continues after it is set.

Counters (both saturate at all-ones and never wrap):
- `stall_cycles` += 1 on each cycle with `rstn`=1 and `pc_en`=0.
- `flush_count` += 1 on each cycle where `if_id_flush`=1 because of `ex_redirect`.

## Timing
- Reset, asynchronous while `rstn`=0:
  - State RUN; `bub_cnt`, `wait_cnt`, both counters and `mem_timeout` are 0.
  - All `*_en` forced to 0 and all flushes to 0.
  - Outputs resume on the first cycle after `rstn` deasserts.
- Control outputs are combinational: zero-cycle latency from inputs, with no registered delay.
- Counter and flag updates appear one cycle after the causing condition.
- A 1-cycle memory access (`dmem_ready`=1 with `mem_req`) causes no stall.
- Reset mid-MEM_WAIT or mid-BUBBLE abandons the saved state; the block returns to RUN with no pending bubble.
- `ex_redirect` and `mem_stall` in the same cycle: the freeze wins and the redirect is applied on the release cycle.

## Test plan
- `LOAD_BUBBLES`=1: lw x5 in EX (`id_ex_rd`=5, `mem_read`=1), ID reads rs1=5 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; next cycle all enables are 1; `stall_cycles`=1.
- `LOAD_BUBBLES`=2, same stimulus → exactly 2 consecutive bubble cycles, then RUN; `stall_cycles`=2. With rd=x0 → no bubble.
- `ex_redirect`=1 together with `load_use`=1 → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1; `flush_count` increments by 1; no bubble follows.
- `mem_req` with `dmem_ready` low for 3 cycles → all 4 enables are 0 and `mem_wb_flush`=1 for 3 cycles, released on the 4th; `stall_cycles`=3.
- `MEM_TIMEOUT`=4, `dmem_ready` held low for 6 cycles → `mem_timeout` rises after the 4th wait cycle and stays 1 after release, until `rstn` pulses low.
- `LOAD_BUBBLES`=2, `mem_stall` arrives during BUBBLE, then reset is asserted mid-wait → after reset: state RUN, counters 0, and no leftover bubble.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RV32I core.
// Resolves load-use bubbles, EX redirects and data-memory wait states, with saturating perf counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic             ex_redirect,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned BUB_W  = $clog2(LOAD_BUBBLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t              state, state_nxt, ret_state, ret_nxt, eff_state;
    logic [BUB_W-1:0]    bub_cnt, bub_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                mem_req, mem_stall, load_use, redirect_acc, timeout_hit;

    assign mem_req   = ex_mem_mem_read | ex_mem_mem_write;
    assign mem_stall = mem_req & ~dmem_ready;
    assign load_use  = id_ex_mem_read & id_ex_reg_write & (id_ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == id_ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == id_ex_rd)));
    assign timeout_hit = mem_stall & (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));

    // State, return state and counters for the hazard FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            ret_state <= RUN;
            bub_cnt   <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            bub_cnt   <= bub_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    // Next-state and control decode; a released MEM_WAIT behaves as its saved state
    always_comb begin
        state_nxt    = state;
        ret_nxt      = ret_state;
        bub_nxt      = bub_cnt;
        wait_nxt     = '0;
        redirect_acc = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        eff_state    = (state == MEM_WAIT) ? ret_state : state;

        if (mem_stall) begin
            state_nxt    = MEM_WAIT;
            ret_nxt      = eff_state;
            wait_nxt     = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            state_nxt = eff_state;
            if (ex_redirect) begin
                redirect_acc = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (eff_state == BUBBLE || load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            case (eff_state)
                BUBBLE: begin
                    bub_nxt = bub_cnt - BUB_W'(1);
                    if (bub_cnt <= BUB_W'(1)) state_nxt = RUN;
                end
                RUN: begin
                    if (LOAD_BUBBLES >= 2 && load_use && !ex_redirect) begin
                        state_nxt = BUBBLE;
                        bub_nxt   = BUB_W'(LOAD_BUBBLES - 1);
                    end
                end
                default: ;
            endcase
        end

        // Reset holds every stage register idle
        if (!rstn) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            mem_wb_flush = 1'b0;
        end
    end

    // Saturating perf counters and sticky timeout flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_acc && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
            if (timeout_hit) mem_timeout <= 1'b1;
        end
    end

endmodule
